// File: rtl/fft_chan_sched_if.sv
// Handshake and result bundle between the channel scheduler,
// the shared FFT engine, the peak detector and the result consumer.
//   master: scheduler side (drives fftstart/fftsel/detclr/results/flags)
//   slave : environment side (drives framevalid/fftdone/detectdone/maxbin/errclr)
interface fft_chan_sched_if;
    logic        framevalid;
    logic        fftstart;
    logic [1:0]  fftsel;
    logic        fftdone;
    logic        detclr;
    logic        detectdone;
    logic [9:0]  maxbin;
    logic [39:0] binout;
    logic        resultvalid;
    logic        busy;
    logic        errclr;
    logic        timeouterr;
    logic [1:0]  errchan;
    logic        overrun;

    modport master (
        input  framevalid, fftdone, detectdone, maxbin, errclr,
        output fftstart, fftsel, detclr, binout, resultvalid,
        output busy, timeouterr, errchan, overrun
    );

    modport slave (
        output framevalid, fftdone, detectdone, maxbin, errclr,
        input  fftstart, fftsel, detclr, binout, resultvalid,
        input  busy, timeouterr, errchan, overrun
    );
endinterface

// File: rtl/fft_chan_sched.sv
// Sequences NCHAN microphone channels through one shared FFT engine and
// peak detector per frame, then publishes all peak bins atomically.
// Ports: clk, reset (sync, active-high), bus (fft_chan_sched_if.master):
//   framevalid in, fftstart/fftsel/detclr out, fftdone/detectdone/maxbin in,
//   binout/resultvalid/busy out, errclr in, timeouterr/errchan/overrun out.
module fft_chan_sched #(
    parameter int NCHAN   = 4,
    parameter int TIMEOUT = 16384
) (
    input  logic             clk,
    input  logic             reset,
    fft_chan_sched_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, FFT_START, FFT_WAIT, DET_CLR,
        DET_WAIT, STORE, DONE, ERR
    } state_t;

    localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);
    localparam logic [1:0]  CLAST = 2'(NCHAN - 1);

    state_t      state;
    state_t      state_nx;
    logic [1:0]  chan;
    logic [15:0] timer;
    logic [9:0]  shadow [4];
    logic [39:0] shadow_packed;
    logic [39:0] binout_q;
    logic        resultvalid_q;
    logic        timeouterr_q;
    logic [1:0]  errchan_q;
    logic        overrun_q;
    logic        wait_first;
    logic        wait_expired;

    // done inputs are levels left over from the previous run during the
    // first wait cycle, so that cycle never counts as completion
    assign wait_first   = (timer == 16'd0);
    assign wait_expired = (timer == TLAST);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:      if (bus.framevalid) state_nx = FFT_START;
            FFT_START: state_nx = FFT_WAIT;
            FFT_WAIT: begin
                if (bus.fftdone && !wait_first) state_nx = DET_CLR;
                else if (wait_expired)          state_nx = ERR;
            end
            DET_CLR:   state_nx = DET_WAIT;
            DET_WAIT: begin
                if (bus.detectdone && !wait_first) state_nx = STORE;
                else if (wait_expired)             state_nx = ERR;
            end
            STORE:     state_nx = (chan == CLAST) ? DONE : FFT_START;
            DONE:      state_nx = IDLE;
            ERR:       state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // unused channel slots stay zero in the published word
    always_comb begin
        shadow_packed = '0;
        for (int k = 0; k < NCHAN; k++) begin
            shadow_packed[10*k +: 10] = shadow[k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            chan          <= '0;
            timer         <= '0;
            binout_q      <= '0;
            resultvalid_q <= 1'b0;
            timeouterr_q  <= 1'b0;
            errchan_q     <= '0;
            overrun_q     <= 1'b0;
            for (int k = 0; k < 4; k++) shadow[k] <= '0;
        end else begin
            state         <= state_nx;
            resultvalid_q <= 1'b0;
            case (state)
                IDLE: chan <= '0;
                FFT_START, DET_CLR: timer <= '0;
                FFT_WAIT, DET_WAIT: begin
                    if (state_nx != state) timer <= '0;
                    else if (timer != '1)  timer <= timer + 16'd1;
                end
                STORE: begin
                    shadow[chan] <= bus.maxbin;
                    if (chan != CLAST) chan <= chan + 2'd1;
                end
                DONE: begin
                    binout_q      <= shadow_packed;
                    resultvalid_q <= 1'b1;
                    chan          <= '0;
                end
                ERR: chan <= '0;
                default: ;
            endcase
            // a new error outranks a simultaneous clear
            if (state == ERR) begin
                timeouterr_q <= 1'b1;
                errchan_q    <= chan;
            end else if (bus.errclr) begin
                timeouterr_q <= 1'b0;
            end
            if (bus.framevalid && state != IDLE) overrun_q <= 1'b1;
            else if (bus.errclr)                 overrun_q <= 1'b0;
        end
    end

    assign bus.fftstart    = (state == FFT_START);
    assign bus.detclr      = (state == DET_CLR);
    assign bus.fftsel      = chan;
    assign bus.busy        = (state != IDLE);
    assign bus.binout      = binout_q;
    assign bus.resultvalid = resultvalid_q;
    assign bus.timeouterr  = timeouterr_q;
    assign bus.errchan     = errchan_q;
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_fft_chan_sched.sv
// Randomized scoreboard bench for fft_chan_sched with behavioural
// FFT-engine and detector models driving the done levels.
module tb_fft_chan_sched;
    localparam int NCHAN   = 4;
    localparam int TIMEOUT = 50;

    typedef struct packed {
        logic        is_err;
        logic [39:0] bin;
        logic [1:0]  ch;
        logic        ovr;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic reset_stim  = 1'b1;
    logic reset_env   = 1'b0;
    logic errclr_stim = 1'b0;
    logic errclr_env  = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int fs_cnt  = 0;
    int dc_cnt  = 0;
    int fs_exp  = 0;
    int dc_exp  = 0;
    int hang_cyc = 0;

    // per-frame configuration shared with the engine models
    int          fd [4];
    int          dd [4];
    logic [9:0]  vals [4];
    int          hang_ch = -1;
    int          rst_ch  = -1;
    bit          coinc   = 1'b0;
    int          frame_id = 0;

    exp_t sbq [$];

    fft_chan_sched_if bus ();

    assign reset      = reset_stim | reset_env;
    assign bus.errclr = errclr_stim | errclr_env;

    fft_chan_sched #(
        .NCHAN   (NCHAN),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial forever #10 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic expect_true(input string nm, input bit cond);
        n_tests++;
        if (!cond) begin
            n_fail++;
            $display("FAIL %s: condition false at cycle %0d", nm, cyc);
        end
    endtask

    // FFT engine / detector models: done levels stay high until one
    // cycle after the restart pulse, then rise again after a delay.
    initial begin : env
        int fa;
        int da;
        int ech;
        int last_id;
        bit ffresh;
        bit rst_chk;
        fa = -1; da = -1; ech = 0; last_id = -1;
        ffresh = 1'b0; rst_chk = 1'b0;
        bus.fftdone    = 1'b1;
        bus.detectdone = 1'b1;
        bus.maxbin     = 10'd0;
        forever begin
            @(negedge clk);
            errclr_env = 1'b0;
            if (rst_chk) begin
                chk("reset_ctl",
                    {bus.fftstart, bus.detclr, bus.resultvalid,
                     bus.busy, bus.fftsel, bus.timeouterr,
                     bus.errchan, bus.overrun}, 64'd0);
                chk("reset_binout", bus.binout, 64'd0);
                rst_chk   = 1'b0;
                reset_env = 1'b0;
                fa = -1;
                da = -1;
            end else begin
                if (bus.fftstart) begin
                    if (frame_id != last_id) begin
                        last_id = frame_id;
                        ech = 0;
                    end else begin
                        ech++;
                    end
                    fs_cnt++;
                    chk("fftsel_start", bus.fftsel, ech);
                    if (ech == hang_ch) hang_cyc = cyc;
                    fa = 0;
                    ffresh = 1'b0;
                end else if (fa >= 0) begin
                    fa++;
                    if (fa == 2) bus.fftdone = 1'b0;
                    if (ech == hang_ch) begin
                        if (fa == TIMEOUT + 1) begin
                            if (coinc) errclr_env = 1'b1;
                            fa = -1;
                        end
                    end else if (fa == 2 + fd[ech & 3]) begin
                        bus.fftdone = 1'b1;
                        ffresh = 1'b1;
                        fa = -1;
                    end
                end
                if (bus.detclr) begin
                    dc_cnt++;
                    chk("detclr_vs_fftstart", bus.fftstart, 64'd0);
                    chk("fftsel_detclr", bus.fftsel, ech);
                    chk("fft_fresh_done", ffresh, 64'd1);
                    da = 0;
                end else if (da >= 0) begin
                    da++;
                    if (da == 2) bus.detectdone = 1'b0;
                    if (ech == rst_ch && da == 4) begin
                        reset_env = 1'b1;
                        rst_chk   = 1'b1;
                        da = -1;
                    end else if (da == 2 + dd[ech & 3]) begin
                        bus.detectdone = 1'b1;
                        bus.maxbin = vals[ech & 3];
                        da = -1;
                    end
                end
            end
        end
    end

    initial begin : mon
        exp_t e;
        bit to_prev;
        to_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.resultvalid) begin
                if (sbq.size() == 0) begin
                    expect_true("unexpected_resultvalid", 1'b0);
                end else begin
                    e = sbq.pop_front();
                    expect_true("result_not_error", !e.is_err);
                    chk("binout", bus.binout, e.bin);
                    chk("overrun_at_result", bus.overrun, e.ovr);
                end
            end
            if (bus.timeouterr && !to_prev) begin
                if (sbq.size() == 0) begin
                    expect_true("unexpected_timeout", 1'b0);
                end else begin
                    e = sbq.pop_front();
                    expect_true("timeout_expected", e.is_err);
                    chk("errchan", bus.errchan, e.ch);
                    chk("binout_kept", bus.binout, e.bin);
                    chk("timeout_latency", cyc - hang_cyc,
                        TIMEOUT + 2);
                    chk("busy_after_err", bus.busy, 64'd0);
                    chk("overrun_at_err", bus.overrun, e.ovr);
                end
            end
            to_prev = bus.timeouterr;
        end
    end

    bit          ovr_model = 1'b0;
    logic [39:0] good_bin  = '0;

    // kind: 0 normal, 1 timeout on channel hang, 2 reset in DET_WAIT ch1
    task automatic run_frame(input int kind, input int hang,
                             input bit with_ovr, input bit do_coinc,
                             input bit directed);
        logic [39:0] b;
        exp_t e;
        int n;
        b = '0;
        for (int k = 0; k < 4; k++) begin
            fd[k] = $urandom_range(1, 40);
            dd[k] = $urandom_range(1, 40);
            vals[k] = 10'($urandom_range(0, 1023));
        end
        if (directed) begin
            vals[0] = 10'd10;
            vals[1] = 10'd200;
            vals[2] = 10'd511;
            vals[3] = 10'd1023;
        end
        for (int k = 0; k < NCHAN; k++) b[10*k +: 10] = vals[k];
        hang_ch = (kind == 1) ? hang : -1;
        rst_ch  = (kind == 2) ? 1 : -1;
        if (kind == 2) dd[1] = 20;
        coinc = do_coinc;
        ovr_model = ovr_model | with_ovr;
        if (do_coinc) ovr_model = 1'b0;
        if (kind == 0) begin
            good_bin = b;
            e = '{is_err: 1'b0, bin: b, ch: 2'd0, ovr: ovr_model};
            sbq.push_back(e);
            fs_exp += NCHAN;
            dc_exp += NCHAN;
        end else if (kind == 1) begin
            e = '{is_err: 1'b1, bin: good_bin, ch: 2'(hang),
                  ovr: ovr_model};
            sbq.push_back(e);
            fs_exp += hang + 1;
            dc_exp += hang;
        end else begin
            fs_exp += 2;
            dc_exp += 2;
        end
        frame_id++;
        bus.framevalid = 1'b1;
        @(negedge clk);
        bus.framevalid = 1'b0;
        if (with_ovr) begin
            repeat (19) @(negedge clk);
            bus.framevalid = 1'b1;
            @(negedge clk);
            bus.framevalid = 1'b0;
        end
        n = 0;
        while (bus.busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) expect_true("frame_finish_bound", 1'b0);
        if (kind == 2) begin
            ovr_model = 1'b0;
            good_bin  = '0;
        end
        repeat (3) @(negedge clk);
        chk("idle_no_restart", bus.busy, 64'd0);
        if (kind == 1 || $urandom_range(0, 3) == 0) begin
            errclr_stim = 1'b1;
            @(negedge clk);
            errclr_stim = 1'b0;
            ovr_model = 1'b0;
            chk("errclr_timeouterr", bus.timeouterr, 64'd0);
            chk("errclr_overrun", bus.overrun, 64'd0);
        end
    endtask

    initial begin : stim
        int r;
        bus.framevalid = 1'b0;
        repeat (3) @(negedge clk);
        reset_stim = 1'b0;
        @(negedge clk);
        chk("init_state",
            {bus.fftstart, bus.detclr, bus.resultvalid, bus.busy,
             bus.fftsel, bus.timeouterr, bus.errchan, bus.overrun},
            64'd0);
        chk("init_binout", bus.binout, 64'd0);

        run_frame(0, -1, 1'b0, 1'b0, 1'b1);
        run_frame(0, -1, 1'b1, 1'b0, 1'b0);
        run_frame(1, 2, 1'b0, 1'b0, 1'b0);
        run_frame(0, -1, 1'b1, 1'b0, 1'b0);
        run_frame(2, -1, 1'b0, 1'b0, 1'b0);
        run_frame(0, -1, 1'b0, 1'b0, 1'b0);
        run_frame(1, $urandom_range(0, NCHAN - 1), 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6) begin
                run_frame(0, -1, r < 2, 1'b0, 1'b0);
            end else begin
                run_frame(1, $urandom_range(0, NCHAN - 1),
                          r == 9, r == 8, 1'b0);
            end
        end

        chk("fftstart_total", fs_cnt, fs_exp);
        chk("detclr_total", dc_cnt, dc_exp);
        chk("scoreboard_empty", sbq.size(), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fft_chan_sched.md
FFT_CHAN_SCHED -- requirements
Module: fft_chan_sched

Interface
REQ-001 Parameter: NCHAN, 4, number of microphone channels sequenced per frame (2..4).
REQ-002 Parameter: TIMEOUT, 16384, max cycles allowed in any wait state (1..65535).
REQ-003 Port: clk  in  1  system clock, 50 MHz.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: framevalid  in  1  new sample frame available for all channels (sampled each cycle).
REQ-006 Port: fftstart  out  1  one-cycle pulse starting the shared FFT engine.
REQ-007 Port: fftsel  out  2  channel currently routed to FFT input and FFT RAM read port.
REQ-008 Port: fftdone  in  1  FFT complete; level, held until next fftstart.
REQ-009 Port: detclr  out  1  one-cycle pulse re-arming the frequency detector.
REQ-010 Port: detectdone  in  1  detector scan complete; sticky until detclr.
REQ-011 Port: maxbin  in  10  detector peak-bin index.
REQ-012 Port: binout  out  40  packed results, channel k at bits [10k+9:10k]; unused channels 0.
REQ-013 Port: resultvalid  out  1  one-cycle pulse, binout updated this cycle.
REQ-014 Port: busy  out  1  high in every state except IDLE.
REQ-015 Port: errclr  in  1  clears sticky error flags.
REQ-016 Port: timeouterr  out  1  sticky, a wait state exceeded TIMEOUT.
REQ-017 Port: errchan  out  2  channel active when timeouterr last set.
REQ-018 Port: overrun  out  1  sticky, framevalid seen while busy.

Function
REQ-019 States SHALL be IDLE, FFT_START, FFT_WAIT, DET_CLR, DET_WAIT, STORE, DONE, ERR.
REQ-020 IDLE: framevalid=1 -> FFT_START next cycle, chan<=0.
REQ-021 FFT_START: fftstart=1 for exactly this cycle, timer<=0 -> FFT_WAIT.
REQ-022 FFT_WAIT: fftdone=1 -> DET_CLR, timer<=0; else timer+1; timer==TIMEOUT-1 without fftdone -> ERR.
REQ-023 FFT_WAIT SHALL ignore fftdone in the first cycle after fftstart (stale level from previous run).
REQ-024 DET_CLR: detclr=1 for exactly this cycle -> DET_WAIT.
REQ-025 DET_WAIT: detectdone=1 -> STORE; same timeout rule as REQ-022 -> ERR; detectdone ignored in first DET_WAIT cycle.
REQ-026 STORE: shadow[chan]<=maxbin; chan==NCHAN-1 -> DONE, else chan+1 -> FFT_START.
REQ-027 DONE: binout<=shadow (all channels atomically), resultvalid=1 this cycle -> IDLE.
REQ-028 ERR: timeouterr<=1, errchan<=chan -> IDLE; no resultvalid; binout unchanged; shadow discarded.
REQ-029 fftsel SHALL equal chan in all states; 0 in IDLE.
REQ-030 Timer: 16 bits unsigned, never wraps; cleared on entry to each wait state.
REQ-031 framevalid=1 while busy=1 -> overrun<=1; frame not queued.
REQ-032 framevalid=1 in IDLE in the same cycle as leaving DONE/ERR is not possible (one-cycle IDLE minimum); a framevalid in DONE/ERR counts as overrun.
REQ-033 errclr clears timeouterr and overrun next cycle; simultaneous set and errclr -> set wins.
REQ-034 Minimum latency framevalid -> resultvalid = sum over channels of (5 + FFT cycles + detector cycles) + 2.
REQ-035 fftstart and detclr SHALL never be high in the same cycle.

Reset
REQ-036 reset=1 at a clk edge: state<=IDLE, chan<=0, timer<=0, shadow<=0, binout<=0, all pulses 0, busy=0, timeouterr=0, errchan=0, overrun=0.
REQ-037 Reset mid-operation SHALL abort immediately; fftstart/detclr low in the cycle following the reset edge; no resultvalid.

Verification
REQ-038 Normal frame: NCHAN=4, models return fftdone after 100 cycles, maxbin=10,200,511,1023 -> one resultvalid pulse, binout={1023,511,200,10}, four fftstart and four detclr pulses.
REQ-039 FFT timeout: TIMEOUT=50, fftdone never rises on chan 2 -> ERR after 50 FFT_WAIT cycles, timeouterr=1, errchan=2, binout unchanged, busy=0.
REQ-040 Overrun: framevalid pulsed at cycle 20 of a frame -> overrun=1, frame completes normally, no second frame started.
REQ-041 Stale level: fftdone held high from prior frame -> scheduler waits for model's fresh done, not exiting FFT_WAIT in first cycle.
REQ-042 Reset in DET_WAIT on chan 1 -> all outputs at reset values next cycle; following framevalid restarts at chan 0.
REQ-043 errclr coincident with new timeout -> timeouterr remains 1.
